fifo_rd_stream: RTL



---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_rd_stream_if.sv | 26 ++
 rtl/fifo_rd_stream.sv | 67 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared encodings for the FIFO read-side drain stage.
package fifo_pkg;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream, flush and beat counter.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
);
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic             flush;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] xfer_cnt;

    // slave: the drain stage itself
    modport slave (
        input  fifo_rdata, fifo_rempty, flush, m_ready,
        output fifo_rinc, m_data, m_valid, xfer_cnt
    );

    // master: FIFO plus consumer side
    modport master (
        output fifo_rdata, fifo_rempty, flush, m_ready,
        input  fifo_rinc, m_data, m_valid, xfer_cnt
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a fall-through FIFO into a 2-entry skid buffer; m_ready never reaches fifo_rinc.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_stream_if.slave   bus
);
    occ_e             r_occ;
    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    // Pop decision uses only registered occupancy, so stall never loops back combinationally.
    assign w_push = !bus.fifo_rempty && (r_occ != OCC_TWO) && !bus.flush && !rst;
    assign w_pop  = (r_occ != OCC_EMPTY) && bus.m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_pop) r_cnt <= r_cnt + CNT_W'(1);
            if (bus.flush) begin
                r_occ <= OCC_EMPTY;
            end else begin
                case (r_occ)
                    OCC_EMPTY: begin
                        if (w_push) begin
                            r_occ  <= OCC_ONE;
                            r_head <= bus.fifo_rdata;
                        end
                    end
                    OCC_ONE: begin
                        if (w_push && !w_pop) begin
                            r_occ  <= OCC_TWO;
                            r_tail <= bus.fifo_rdata;
                        end else if (w_push && w_pop) begin
                            r_head <= bus.fifo_rdata;
                        end else if (w_pop) begin
                            r_occ <= OCC_EMPTY;
                        end
                    end
                    OCC_TWO: begin
                        if (w_pop) begin
                            r_occ  <= OCC_ONE;
                            r_head <= r_tail;
                        end
                    end
                    default: r_occ <= OCC_EMPTY;
                endcase
            end
        end
    end

    assign bus.fifo_rinc = w_push;
    assign bus.m_valid   = (r_occ != OCC_EMPTY);
    assign bus.m_data    = r_head;
    assign bus.xfer_cnt  = r_cnt;
endmodule
